// File: rtl/ps_mem_arb2_if.sv
// Bus bundle for the picorv32 valid/ready memory handshake.
// The master side drives the request and the slave side answers it.
`timescale 1ns/1ps
interface ps_mem_arb2_if;
  logic        mem_valid;
  logic [22:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/ps_mem_arb2.sv
// Two-requester arbiter (fetch = m0, load/store = m1) in front of the PSRAM bridge.
// Round-robin or fixed grant, one-cycle valid-low gap, tag-init block, sticky watchdog.
`timescale 1ns/1ps
module ps_mem_arb2 #(
  parameter int unsigned FIXED_PRIO  = 0,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                 cpuclk,
  input  logic                 WSHRST,
  ps_mem_arb2_if.slave         m0,
  ps_mem_arb2_if.slave         m1,
  ps_mem_arb2_if.master        ps,
  input  logic                 run_inittag,
  output logic [1:0]           arb_grant,
  output logic                 arb_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

  state_t      state, state_nx;
  logic [1:0]  grant_nx;
  logic        last_winner, last_nx;
  logic [15:0] busy_cnt, cnt_inc;
  logic        busy, sel1, gnt_valid, pick1;

  assign busy      = (state == BUSY);
  assign sel1      = busy & arb_grant[1];
  assign gnt_valid = (arb_grant[0] & m0.mem_valid) | (arb_grant[1] & m1.mem_valid);
  assign cnt_inc   = (busy_cnt == '1) ? busy_cnt : busy_cnt + 16'd1;

  always_comb begin
    pick1    = m1.mem_valid;
    state_nx = state;
    grant_nx = arb_grant;
    last_nx  = last_winner;
    // on a tie, round-robin favours the port that did not win last time
    if (m0.mem_valid && m1.mem_valid)
      pick1 = (FIXED_PRIO != 0) ? 1'b0 : ~last_winner;
    case (state)
      IDLE: begin
        if (!run_inittag && (m0.mem_valid || m1.mem_valid)) begin
          state_nx = BUSY;
          grant_nx = pick1 ? 2'b10 : 2'b01;
        end
      end
      BUSY: begin
        if (ps.mem_ready) begin
          state_nx = GAP;
          grant_nx = '0;
          last_nx  = arb_grant[1];
        end else if (!gnt_valid) begin
          state_nx = GAP;
          grant_nx = '0;
        end
      end
      GAP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge cpuclk or posedge WSHRST) begin
    if (WSHRST) begin
      state       <= IDLE;
      arb_grant   <= '0;
      last_winner <= 1'b1;
      busy_cnt    <= '0;
      arb_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      arb_grant   <= grant_nx;
      last_winner <= last_nx;
      if (state == IDLE && state_nx == BUSY) begin
        busy_cnt <= '0;
      end else if (busy) begin
        busy_cnt <= cnt_inc;
        // flag fires as the counter reaches the limit, i.e. after that many BUSY cycles
        if (TO_LIM != '0 && cnt_inc == TO_LIM)
          arb_timeout <= 1'b1;
      end
    end
  end

  // Outside BUSY the bus idles on port 0's address/data with no byte enables.
  assign ps.mem_valid = busy & gnt_valid;
  assign ps.mem_addr  = sel1 ? m1.mem_addr  : m0.mem_addr;
  assign ps.mem_wdata = sel1 ? m1.mem_wdata : m0.mem_wdata;
  assign ps.mem_wstrb = busy ? (sel1 ? m1.mem_wstrb : m0.mem_wstrb) : '0;

  assign m0.mem_ready = busy & arb_grant[0] & ps.mem_ready;
  assign m1.mem_ready = busy & arb_grant[1] & ps.mem_ready;
  assign m0.mem_rdata = ps.mem_rdata;
  assign m1.mem_rdata = ps.mem_rdata;

endmodule

// File: tb/tb_ps_mem_arb2.sv
// Scoreboard bench for ps_mem_arb2: a round-robin instance (watchdog 8) and a
// fixed-priority instance (watchdog off) share master stimulus; each has its own bridge model.
`timescale 1ns/1ps
module tb_ps_mem_arb2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        run_inittag;
  logic        m0_valid, m1_valid;
  logic [22:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;

  ps_mem_arb2_if rr_m0 ();
  ps_mem_arb2_if rr_m1 ();
  ps_mem_arb2_if rr_ps ();
  ps_mem_arb2_if fp_m0 ();
  ps_mem_arb2_if fp_m1 ();
  ps_mem_arb2_if fp_ps ();

  assign rr_m0.mem_valid = m0_valid;
  assign rr_m0.mem_addr  = m0_addr;
  assign rr_m0.mem_wdata = m0_wdata;
  assign rr_m0.mem_wstrb = m0_wstrb;
  assign rr_m1.mem_valid = m1_valid;
  assign rr_m1.mem_addr  = m1_addr;
  assign rr_m1.mem_wdata = m1_wdata;
  assign rr_m1.mem_wstrb = m1_wstrb;
  assign fp_m0.mem_valid = m0_valid;
  assign fp_m0.mem_addr  = m0_addr;
  assign fp_m0.mem_wdata = m0_wdata;
  assign fp_m0.mem_wstrb = m0_wstrb;
  assign fp_m1.mem_valid = m1_valid;
  assign fp_m1.mem_addr  = m1_addr;
  assign fp_m1.mem_wdata = m1_wdata;
  assign fp_m1.mem_wstrb = m1_wstrb;

  logic [1:0] rr_grant, fp_grant;
  logic       rr_to, fp_to;

  ps_mem_arb2 #(.FIXED_PRIO(0), .TIMEOUT_CYC(8)) dut_rr (
    .cpuclk(clk), .WSHRST(rst), .m0(rr_m0), .m1(rr_m1), .ps(rr_ps),
    .run_inittag(run_inittag), .arb_grant(rr_grant), .arb_timeout(rr_to)
  );

  ps_mem_arb2 #(.FIXED_PRIO(1), .TIMEOUT_CYC(0)) dut_fp (
    .cpuclk(clk), .WSHRST(rst), .m0(fp_m0), .m1(fp_m1), .ps(fp_ps),
    .run_inittag(run_inittag), .arb_grant(fp_grant), .arb_timeout(fp_to)
  );

  typedef struct {
    logic [1:0]  g;
    logic [31:0] rd;
  } exp_t;

  exp_t q_rr[$];
  exp_t q_fp[$];
  int checks  = 0;
  int errors  = 0;
  int done_rr = 0;
  int done_fp = 0;

  logic        bmode_man;
  int          bdelay;
  logic        man_ready;
  logic [31:0] man_rdata;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] resp(input logic [22:0] a);
    return (a == 23'h000100) ? 32'hDEADBEEF : (32'hA500_0000 | {9'd0, a});
  endfunction

  function automatic void bstep(input logic v, input logic [22:0] a, inout int cnt,
                                inout logic rdy, inout logic [31:0] rd);
    if (bmode_man) begin
      rdy = man_ready;
      rd  = man_rdata;
      cnt = 0;
    end else if (rdy) begin
      rdy = 1'b0;
      cnt = 0;
    end else if (v) begin
      cnt++;
      if (cnt >= bdelay) begin
        rdy = 1'b1;
        rd  = resp(a);
      end
    end else begin
      cnt = 0;
    end
  endfunction

  task automatic bridge();
    int c_rr = 0;
    int c_fp = 0;
    logic r;
    logic [31:0] d;
    rr_ps.mem_ready = 1'b0;
    rr_ps.mem_rdata = '0;
    fp_ps.mem_ready = 1'b0;
    fp_ps.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      r = rr_ps.mem_ready; d = rr_ps.mem_rdata;
      bstep(rr_ps.mem_valid, rr_ps.mem_addr, c_rr, r, d);
      rr_ps.mem_ready = r; rr_ps.mem_rdata = d;
      r = fp_ps.mem_ready; d = fp_ps.mem_rdata;
      bstep(fp_ps.mem_valid, fp_ps.mem_addr, c_fp, r, d);
      fp_ps.mem_ready = r; fp_ps.mem_rdata = d;
    end
  endtask

  function automatic void score(input int d, input logic [1:0] rv, input logic [1:0] g,
                                input logic [31:0] rd0, input logic [31:0] rd1);
    exp_t  e;
    string p;
    p = (d == 0) ? "rr" : "fp";
    if ((d == 0 && q_rr.size() == 0) || (d != 0 && q_fp.size() == 0)) begin
      chk({p, "_unexpected_ready"}, 32'(rv), 32'd0);
      return;
    end
    if (d == 0) begin e = q_rr.pop_front(); done_rr++; end
    else begin e = q_fp.pop_front(); done_fp++; end
    chk({p, "_ready_owner"}, 32'(rv), 32'(e.g));
    chk({p, "_grant_at_done"}, 32'(g), 32'(e.g));
    chk({p, "_rdata"}, e.g[1] ? rd1 : rd0, e.rd);
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rr_m0.mem_ready || rr_m1.mem_ready)
          score(0, {rr_m1.mem_ready, rr_m0.mem_ready}, rr_grant, rr_m0.mem_rdata, rr_m1.mem_rdata);
        if (fp_m0.mem_ready || fp_m1.mem_ready)
          score(1, {fp_m1.mem_ready, fp_m0.mem_ready}, fp_grant, fp_m0.mem_rdata, fp_m1.mem_rdata);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int t);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (done_rr >= t && done_fp >= t) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_done", 32'(ok), 32'd1);
    #1;
  endtask

  function automatic void push2(input logic [1:0] g, input logic [31:0] rd);
    exp_t e;
    e.g = g;
    e.rd = rd;
    q_rr.push_back(e);
    q_fp.push_back(e);
  endfunction

  initial begin
    int nv;
    run_inittag = 1'b0;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    bmode_man = 1'b0; bdelay = 3; man_ready = 1'b0; man_rdata = '0;
    fork
      bridge();
      monitor();
      begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "stopped");
      end
    join_none

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'({rr_grant, fp_grant}), 32'd0);
    chk("rst_ps_valid", 32'({rr_ps.mem_valid, fp_ps.mem_valid}), 32'd0);
    chk("rst_readies", 32'({rr_m0.mem_ready, rr_m1.mem_ready}), 32'd0);
    chk("rst_timeout", 32'({rr_to, fp_to}), 32'd0);
    cyc();
    rst = 1'b0;

    // continuous requests on both ports
    cyc();
    bdelay = 3;
    m0_valid = 1'b1; m0_addr = 23'h000010;
    m1_valid = 1'b1; m1_addr = 23'h000020;
    q_rr.push_back('{2'b01, 32'hA500_0010});
    q_rr.push_back('{2'b10, 32'hA500_0020});
    q_rr.push_back('{2'b01, 32'hA500_0010});
    q_rr.push_back('{2'b10, 32'hA500_0020});
    for (int i = 0; i < 4; i++) q_fp.push_back('{2'b01, 32'hA500_0010});
    wait_done(4);
    m0_valid = 1'b0; m1_valid = 1'b0;

    // single port 0 read
    cyc();
    bdelay = 5;
    m0_valid = 1'b1; m0_addr = 23'h000100; m0_wstrb = 4'h0;
    push2(2'b01, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_pre_grant", 32'(rr_grant), 32'd0);
    @(negedge clk);
    chk("t1_grant", 32'(rr_grant), 32'd1);
    chk("t1_ps_valid", 32'(rr_ps.mem_valid), 32'd1);
    chk("t1_ps_addr", 32'(rr_ps.mem_addr), 32'h100);
    wait_done(5);
    m0_valid = 1'b0;
    @(negedge clk);
    chk("t1_gap", 32'({rr_ps.mem_valid, rr_grant}), 32'd0);

    // tag init blocks the grant
    cyc();
    run_inittag = 1'b1;
    m1_valid = 1'b1; m1_addr = 23'h000040; m1_wdata = 32'h12345678; m1_wstrb = 4'hF;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nv += int'(rr_ps.mem_valid) + int'(fp_ps.mem_valid);
    end
    chk("inittag_valid_low", 32'(nv), 32'd0);
    cyc();
    run_inittag = 1'b0;
    push2(2'b10, 32'hA500_0040);
    @(negedge clk);
    chk("inittag_fall_grant", 32'(rr_grant), 32'd0);
    @(negedge clk);
    chk("inittag_grant", 32'(rr_grant), 32'd2);
    chk("inittag_wstrb", 32'(rr_ps.mem_wstrb), 32'hF);
    chk("inittag_wdata", rr_ps.mem_wdata, 32'h12345678);
    chk("inittag_addr", 32'(rr_ps.mem_addr), 32'h40);
    wait_done(6);
    m1_valid = 1'b0; m1_wstrb = 4'h0;

    // watchdog on a hung bridge
    cyc();
    bmode_man = 1'b1; man_ready = 1'b0;
    m0_valid = 1'b1; m0_addr = 23'h000200;
    @(negedge clk);
    for (int k = 1; k <= 8; k++) @(negedge clk);
    chk("to_before_limit", 32'(rr_to), 32'd0);
    @(negedge clk);
    chk("to_at_limit", 32'(rr_to), 32'd1);
    chk("to_disabled", 32'(fp_to), 32'd0);
    chk("to_not_aborted", 32'(rr_ps.mem_valid), 32'd1);
    cyc();
    man_ready = 1'b1; man_rdata = 32'h0BADF00D;
    push2(2'b01, 32'h0BADF00D);
    cyc();
    m0_valid = 1'b0;
    @(negedge clk);
    chk("gap_ready_ignored", 32'({rr_m1.mem_ready, rr_m0.mem_ready}), 32'd0);
    chk("to_sticky", 32'(rr_to), 32'd1);
    cyc();
    @(negedge clk);
    chk("idle_ready_ignored", 32'({rr_m1.mem_ready, rr_m0.mem_ready}), 32'd0);
    cyc();
    man_ready = 1'b0;

    // reset in the middle of a port 1 transaction
    cyc();
    m1_valid = 1'b1; m1_addr = 23'h000080;
    @(negedge clk);
    @(negedge clk);
    chk("t5_busy_grant", 32'(rr_grant), 32'd2);
    cyc();
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(rr_ps.mem_valid), 32'd0);
    chk("t5_rst_grant", 32'(rr_grant), 32'd0);
    chk("t5_rst_ready", 32'({rr_m1.mem_ready, rr_m0.mem_ready}), 32'd0);
    chk("t5_rst_timeout", 32'(rr_to), 32'd0);
    cyc();
    rst = 1'b0;
    bmode_man = 1'b0; bdelay = 3;
    m0_valid = 1'b1; m0_addr = 23'h000300;
    push2(2'b01, 32'hA500_0300);
    push2(2'b10, 32'hA500_0080);
    @(negedge clk);
    @(negedge clk);
    chk("t5_first_grant", 32'(rr_grant), 32'd1);
    wait_done(8);
    m0_valid = 1'b0;
    wait_done(9);
    m1_valid = 1'b0;

    repeat (3) cyc();
    chk("rr_queue_empty", 32'(q_rr.size()), 32'd0);
    chk("fp_queue_empty", 32'(q_fp.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
